// File: rtl/pcf8575_pkg.sv
// Shared types and constants for the PCF8575 I2C target emulation.
package pcf8575_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrByte,
        StWrAck,
        StRdByte,
        StRdAck,
        StIgnore
    } state_e;

    localparam logic [3:0]  BaseAddr = 4'b0100;
    localparam int unsigned IdxW     = 1;
    localparam int unsigned ByteW    = 8;
    localparam int unsigned P0Lsb    = 0;
    localparam int unsigned P1Lsb    = 8;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizer plus consecutive-sample glitch filter for one open-drain bus line.
module i2c_line_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CntW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CntW-1:0]        cnt_q;
    logic                   level_q, rise_q, fall_q;
    logic                   sample;

    assign sample = sync_q[SYNC_STAGES-1];

    // Idle bus is high, so reset to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (sample == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntW'(FILT_LEN - 1)) begin
                level_q <= sample;
                rise_q  <= sample;
                fall_q  <= ~sample;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/pcf8575_i2c_target.sv
// PCF8575-compatible I2C target: 16-bit quasi-bidirectional port with interrupt.
module pcf8575_i2c_target
    import pcf8575_pkg::*;
#(
    parameter logic [2:0]  ADDR_PINS   = 3'b000,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 3
) (
    input  logic        clkin,
    input  logic        reset_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic [15:0] p_in,
    output logic [15:0] p_out,
    output logic        int_n,
    output logic        busy
);

    localparam logic [6:0] OwnAddr = {BaseAddr, ADDR_PINS};

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;
    logic start_cond, stop_cond;

    state_e            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              rw_q, rw_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [15:0]       snap_q, snap_d;
    logic [15:0]       pin_q;
    logic [15:0]       p_out_q, p_out_d;
    logic              sda_oe_q, sda_oe_d;
    logic              int_n_q, int_n_d;
    logic              busy_q, busy_d;
    logic              int_clr;
    logic [7:0]        rd_byte;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk   (clkin),
        .rst_n (reset_n),
        .din   (scl_i),
        .level (scl_f),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk   (clkin),
        .rst_n (reset_n),
        .din   (sda_i),
        .level (sda_f),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    assign start_cond = sda_fall & scl_f;
    assign stop_cond  = sda_rise & scl_f;
    assign rd_byte    = idx_q[0] ? snap_q[P1Lsb +: ByteW] : snap_q[P0Lsb +: ByteW];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rw_d      = rw_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        p_out_d   = p_out_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        int_clr   = 1'b0;

        if (start_cond) begin
            state_d   = StAddr;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (stop_cond) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                StAddr: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (shift_q[6:0] == OwnAddr) begin
                                rw_d   = sda_f;
                                busy_d = 1'b1;
                            end else begin
                                state_d = StIgnore;
                            end
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d  = StAddrAck;
                        sda_oe_d = 1'b1;
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        idx_d     = '0;
                        if (rw_q) begin
                            snap_d   = pin_q;
                            sda_oe_d = ~pin_q[P0Lsb + ByteW - 1];
                            int_clr  = 1'b1;
                            state_d  = StRdByte;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = StWrByte;
                        end
                    end
                end
                StWrByte: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d  = StWrAck;
                        sda_oe_d = 1'b1;
                    end
                end
                StWrAck: begin
                    // Commit only once the ACK clock completes; a truncated byte is dropped.
                    if (scl_fall) begin
                        if (idx_q[0]) p_out_d[P1Lsb +: ByteW] = shift_q;
                        else          p_out_d[P0Lsb +: ByteW] = shift_q;
                        idx_d     = idx_q + IdxW'(1);
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b0;
                        snap_d    = pin_q;
                        int_clr   = 1'b1;
                        state_d   = StWrByte;
                    end
                end
                StRdByte: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = StRdAck;
                        end else begin
                            sda_oe_d = ~rd_byte[~bit_cnt_q[2:0]];
                        end
                    end
                end
                StRdAck: begin
                    // bit_cnt doubles as the "master acknowledged" flag here.
                    if (scl_rise) begin
                        if (!sda_f) begin
                            bit_cnt_d = 4'd1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = StIgnore;
                        end
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        idx_d     = idx_q + IdxW'(1);
                        bit_cnt_d = '0;
                        state_d   = StRdByte;
                        if (idx_q[0]) begin
                            snap_d   = pin_q;
                            sda_oe_d = ~pin_q[P0Lsb + ByteW - 1];
                        end else begin
                            sda_oe_d = ~snap_q[P1Lsb + ByteW - 1];
                        end
                    end
                end
                StIdle, StIgnore: sda_oe_d = 1'b0;
                default: state_d = StIdle;
            endcase
        end

        if (int_clr)               int_n_d = 1'b1;
        else if (pin_q != snap_q)  int_n_d = 1'b0;
        else                       int_n_d = int_n_q;
    end

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            rw_q      <= 1'b0;
            idx_q     <= '0;
            snap_q    <= '1;
            pin_q     <= '1;
            p_out_q   <= '1;
            sda_oe_q  <= 1'b0;
            int_n_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rw_q      <= rw_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            pin_q     <= p_in;
            p_out_q   <= p_out_d;
            sda_oe_q  <= sda_oe_d;
            int_n_q   <= int_n_d;
            busy_q    <= busy_d;
        end
    end

    assign sda_oe = sda_oe_q;
    assign p_out  = p_out_q;
    assign int_n  = int_n_q;
    assign busy   = busy_q;

endmodule
